// File: rtl/nibble_unpacker_pkg.sv
// Shared definitions for the nibble unpacker: state encoding and default piece width.
package nibble_unpacker_pkg;

  localparam int NIBBLE_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_unpacker_if.sv
// Packed-word input and piece output handshakes of the nibble unpacker.
interface nibble_unpacker_if
  import nibble_unpacker_pkg::*;
#(
  parameter int NIBBLE_W = NIBBLE_W_DEF
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2*NIBBLE_W-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [NIBBLE_W-1:0]   out_data;
  logic                  out_last;

  // master: the surrounding fabric (word producer and piece consumer)
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/nibble_unpacker.sv
// Splits each {hi, lo} word into two NIBBLE_W pieces, one per cycle, with no bubble
// between back-to-back words; counts fully emitted words.
module nibble_unpacker
  import nibble_unpacker_pkg::*;
#(
  parameter int NIBBLE_W  = NIBBLE_W_DEF,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  nibble_unpacker_if.slave bus,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int WORD_W = 2 * NIBBLE_W;

  function automatic logic [NIBBLE_W-1:0] first_half(input logic [WORD_W-1:0] w);
    return MSB_FIRST ? w[WORD_W-1:NIBBLE_W] : w[NIBBLE_W-1:0];
  endfunction

  function automatic logic [NIBBLE_W-1:0] second_half(input logic [WORD_W-1:0] w);
    return MSB_FIRST ? w[NIBBLE_W-1:0] : w[WORD_W-1:NIBBLE_W];
  endfunction

  state_e              state_q, state_d;
  logic [NIBBLE_W-1:0] hold_q, hold_d;
  logic [NIBBLE_W-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                in_ready;
  logic                in_xfer;
  logic                out_xfer;

  // In SECOND the slot frees exactly when the second piece leaves, enabling reload without a bubble.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_EMPTY:  in_ready = 1'b1;
      ST_SECOND: in_ready = bus.out_ready;
      default:   in_ready = 1'b0;
    endcase
  end

  assign in_xfer  = bus.in_valid && in_ready;
  assign out_xfer = valid_q && bus.out_ready;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          state_d = ST_FIRST;
          hold_d  = second_half(bus.in_data);
          data_d  = first_half(bus.in_data);
          valid_d = 1'b1;
          last_d  = 1'b0;
        end
      end
      ST_FIRST: begin
        if (out_xfer) begin
          state_d = ST_SECOND;
          data_d  = hold_q;
          last_d  = 1'b1;
        end
      end
      ST_SECOND: begin
        if (out_xfer) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (in_xfer) begin
            state_d = ST_FIRST;
            hold_d  = second_half(bus.in_data);
            data_d  = first_half(bus.in_data);
            valid_d = 1'b1;
            last_d  = 1'b0;
          end else begin
            state_d = ST_EMPTY;
            data_d  = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end
        end
      end
      default: begin
        // Unused encoding: drop any output and return to EMPTY.
        state_d = ST_EMPTY;
        data_d  = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      hold_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_last  = last_q;
  assign word_cnt      = cnt_q;

endmodule

// File: tb/tb_nibble_unpacker.sv
// Bench for nibble_unpacker: an MSB-first/8-bit-counter and an LSB-first/2-bit-counter
// instance share the same stimulus and are checked side by side.
module tb_nibble_unpacker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;
  logic [7:0] cnt_m;
  logic [1:0] cnt_l;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nibble_unpacker_if #(.NIBBLE_W(4)) im ();
  nibble_unpacker_if #(.NIBBLE_W(4)) il ();

  assign im.in_valid  = in_valid;
  assign im.in_data   = in_data;
  assign im.out_ready = out_ready;
  assign il.in_valid  = in_valid;
  assign il.in_data   = in_data;
  assign il.out_ready = out_ready;

  nibble_unpacker #(.NIBBLE_W(4), .MSB_FIRST(1'b1), .CNT_W(8)) u_m (
    .clk(clk), .rst_n(rst_n), .bus(im), .word_cnt(cnt_m)
  );

  nibble_unpacker #(.NIBBLE_W(4), .MSB_FIRST(1'b0), .CNT_W(2)) u_l (
    .clk(clk), .rst_n(rst_n), .bus(il), .word_cnt(cnt_l)
  );

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       orr;
    logic       ev;
    logic [3:0] em;
    logic [3:0] el;
    logic       elast;
    logic       erdy;
    logic [7:0] ecnt;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic iv, input logic [7:0] d, input logic orr);
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = orr;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [4:0] qm[$];
  logic [4:0] ql[$];
  logic [4:0] em, el;
  logic [3:0] ra, rb;
  logic       pend, stall, pl;
  logic [3:0] pdm, pdl;
  int         exp_cnt;

  initial begin
    tbl[0]  = '{1'b1, 8'h5F, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 8'd0};
    tbl[1]  = '{1'b1, 8'hA0, 1'b1, 1'b1, 4'h5, 4'hF, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 8'hA0, 1'b1, 1'b1, 4'hF, 4'h5, 1'b1, 1'b1, 8'd0};
    tbl[3]  = '{1'b1, 8'hB6, 1'b1, 1'b1, 4'hA, 4'h0, 1'b0, 1'b0, 8'd1};
    tbl[4]  = '{1'b1, 8'hB6, 1'b1, 1'b1, 4'h0, 4'hA, 1'b1, 1'b1, 8'd1};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 4'hB, 4'h6, 1'b0, 1'b0, 8'd2};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 4'h6, 4'hB, 1'b1, 1'b1, 8'd2};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 8'd3};
    tbl[8]  = '{1'b1, 8'h5F, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 8'd3};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 4'h5, 4'hF, 1'b0, 1'b0, 8'd3};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'h5, 4'hF, 1'b0, 1'b0, 8'd3};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'h5, 4'hF, 1'b0, 1'b0, 8'd3};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'h5, 4'hF, 1'b0, 1'b0, 8'd3};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 4'h5, 4'hF, 1'b0, 1'b0, 8'd3};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'hF, 4'h5, 1'b1, 1'b0, 8'd3};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 4'hF, 4'h5, 1'b1, 1'b1, 8'd3};
    tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 8'd4};

    // Reset values
    #3;
    chk("rst_valid", 32'(im.out_valid), 32'd0);
    chk("rst_data", 32'(im.out_data), 32'd0);
    chk("rst_last", 32'(im.out_last), 32'd0);
    chk("rst_cnt", 32'(cnt_m), 32'd0);
    chk("rst_in_ready", 32'(im.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic split, LSB-first ordering and backpressure
    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].iv, tbl[i].d, tbl[i].orr);
      chk($sformatf("v%0d_valid", i), 32'({im.out_valid, il.out_valid}), 32'({tbl[i].ev, tbl[i].ev}));
      if (tbl[i].ev) begin
        chk($sformatf("v%0d_data_msb", i), 32'(im.out_data), 32'(tbl[i].em));
        chk($sformatf("v%0d_data_lsb", i), 32'(il.out_data), 32'(tbl[i].el));
        chk($sformatf("v%0d_last", i), 32'({im.out_last, il.out_last}), 32'({tbl[i].elast, tbl[i].elast}));
      end
      chk($sformatf("v%0d_in_ready", i), 32'({im.in_ready, il.in_ready}), 32'({tbl[i].erdy, tbl[i].erdy}));
      chk($sformatf("v%0d_cnt_m", i), 32'(cnt_m), 32'(tbl[i].ecnt));
      chk($sformatf("v%0d_cnt_l", i), 32'(cnt_l), 32'(tbl[i].ecnt[1:0]));
    end

    // Reset mid-word, asserted between clock edges
    cyc(1'b1, 8'hA0, 1'b1);
    @(posedge clk);
    #2;
    chk("mid_pre_data", 32'(im.out_data), 32'hA);
    rst_n = 1'b0;
    #1;
    chk("mid_async_valid", 32'({im.out_valid, il.out_valid}), 32'd0);
    chk("mid_async_cnt", 32'(cnt_m), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk($sformatf("mid_idle%0d_valid", i), 32'(im.out_valid), 32'd0);
    end
    cyc(1'b1, 8'h5F, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("mid_p0", 32'({im.out_valid, im.out_last, im.out_data}), 32'({1'b1, 1'b0, 4'h5}));
    cyc(1'b0, 8'h00, 1'b1);
    chk("mid_p1", 32'({im.out_valid, im.out_last, im.out_data}), 32'({1'b1, 1'b1, 4'hF}));
    cyc(1'b0, 8'h00, 1'b1);
    chk("mid_done_valid", 32'(im.out_valid), 32'd0);
    chk("mid_done_cnt", 32'(cnt_m), 32'd1);

    // Counter wrap on the 2-bit counter
    do_reset();
    for (int w = 1; w <= 5; w++) begin
      cyc(1'b1, 8'(w * 8'h13), 1'b1);
      cyc(1'b0, 8'h00, 1'b1);
      cyc(1'b0, 8'h00, 1'b1);
      cyc(1'b0, 8'h00, 1'b1);
      chk($sformatf("wrap%0d_cnt_l", w), 32'(cnt_l), 32'(w % 4));
      chk($sformatf("wrap%0d_cnt_m", w), 32'(cnt_m), 32'(w));
    end

    // Round trip: random {a,b} words with random gaps and backpressure
    do_reset();
    pend = 1'b0;
    stall = 1'b0;
    pl = 1'b0;
    pdm = 4'h0;
    pdl = 4'h0;
    ra = 4'h0;
    rb = 4'h0;
    exp_cnt = 0;
    for (int c = 0; c < 800; c++) begin
      if (!pend && ($urandom_range(9) < 7)) begin
        ra = 4'($urandom);
        rb = 4'($urandom);
        pend = 1'b1;
      end
      @(negedge clk);
      in_valid  = pend;
      in_data   = {ra, rb};
      out_ready = ($urandom_range(9) < 7);
      #1;
      chk("rt_cnt_m", 32'(cnt_m), 32'(exp_cnt % 256));
      chk("rt_cnt_l", 32'(cnt_l), 32'(exp_cnt % 4));
      chk("rt_valid", 32'({im.out_valid, il.out_valid}), (qm.size() != 0) ? 32'd3 : 32'd0);
      if (stall)
        chk("rt_stable", 32'({im.out_valid, im.out_last, im.out_data, il.out_last, il.out_data}),
            32'({1'b1, pl, pdm, pl, pdl}));
      if (im.out_valid && out_ready && qm.size() != 0) begin
        em = qm.pop_front();
        el = ql.pop_front();
        chk("rt_piece_m", 32'({im.out_last, im.out_data}), 32'(em));
        chk("rt_piece_l", 32'({il.out_last, il.out_data}), 32'(el));
        if (em[4]) exp_cnt++;
      end
      if (in_valid && im.in_ready) begin
        qm.push_back({1'b0, ra});
        qm.push_back({1'b1, rb});
        ql.push_back({1'b0, rb});
        ql.push_back({1'b1, ra});
        pend = 1'b0;
      end
      stall = im.out_valid && !out_ready;
      pl  = im.out_last;
      pdm = im.out_data;
      pdl = il.out_data;
    end

    for (int c = 0; c < 6; c++) begin
      cyc(1'b0, 8'h00, 1'b1);
      if (im.out_valid && qm.size() != 0) begin
        em = qm.pop_front();
        el = ql.pop_front();
        chk("drain_piece_m", 32'({im.out_last, im.out_data}), 32'(em));
        chk("drain_piece_l", 32'({il.out_last, il.out_data}), 32'(el));
        if (em[4]) exp_cnt++;
      end
    end
    chk("drain_empty", 32'(qm.size()), 32'd0);
    chk("drain_valid", 32'(im.out_valid), 32'd0);
    chk("drain_cnt", 32'(cnt_m), 32'(exp_cnt % 256));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
